// File: rtl/file_core_pkg.sv
// Shared definitions for file_core: operand opcodes and the 1011 detector state encoding.
package file_core_pkg;

  localparam int unsigned WIDTH_DEF = 4;
  localparam int unsigned OP_W      = 2;

  localparam logic [OP_W-1:0] OP_HOLD = 2'b00;
  localparam logic [OP_W-1:0] OP_LOAD = 2'b01;
  localparam logic [OP_W-1:0] OP_ADD  = 2'b10;
  localparam logic [OP_W-1:0] OP_XOR  = 2'b11;

  // Each state is named after the longest pattern prefix matched so far.
  typedef enum logic [2:0] {
    S0    = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    S1011 = 3'd4
  } state_t;

endpackage

// File: rtl/file_core_if.sv
// Operand bus and serial stream bundle for file_core.
interface file_core_if #(
  parameter int unsigned WIDTH = file_core_pkg::WIDTH_DEF
);
  logic [WIDTH-1:0] data_in;
  logic             a;
  logic             b;
  logic             x;
  logic [WIDTH-1:0] data_out;
  logic             out;

  modport master (output data_in, output a, output b, output x,
                  input  data_out, input out);
  modport slave  (input  data_in, input  a, input  b, input  x,
                  output data_out, output out);
endinterface

// File: rtl/file_core_seq_detect_1011.sv
// Moore detector for the overlapping serial pattern 1011; out is high only in S1011.
module seq_detect_1011
  import file_core_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic x,
  output logic out
);

  state_t r_state;
  state_t w_next;
  logic   r_out;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S0:      w_next = x ? S1    : S0;
      S1:      w_next = x ? S1    : S10;
      S10:     w_next = x ? S101  : S0;
      S101:    w_next = x ? S1011 : S10;
      S1011:   w_next = x ? S1    : S10;
      default: w_next = S0;
    endcase
  end

  // Flag is registered alongside the state so it tracks the state exactly.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S0;
      r_out   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_out   <= (w_next == S1011);
    end
  end

  assign out = r_out;

endmodule

// File: rtl/file_core.sv
// Operand register driven by opcode {a,b} plus an independent 1011 sequence detector.
module file_core
  import file_core_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  file_core_if.slave  bus
);

  logic [WIDTH-1:0] r_data;
  logic [OP_W-1:0]  w_op;
  logic             w_out;

  assign w_op = {bus.a, bus.b};

  // Add wraps modulo 2^WIDTH; the carry is dropped by the sized sum.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data <= '0;
    end else begin
      unique case (w_op)
        OP_HOLD: r_data <= r_data;
        OP_LOAD: r_data <= bus.data_in;
        OP_ADD:  r_data <= WIDTH'(r_data + bus.data_in);
        OP_XOR:  r_data <= r_data ^ bus.data_in;
        default: r_data <= r_data;
      endcase
    end
  end

  seq_detect_1011 u_detect (
    .clk (clk),
    .rst (rst),
    .x   (bus.x),
    .out (w_out)
  );

  assign bus.data_out = r_data;
  assign bus.out      = w_out;

endmodule

// File: tb/tb_file_core.sv
// Directed and randomized checks of the file_core operand register and 1011 detector.
module tb_file_core;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  file_core_if #(.WIDTH(4)) bus ();

  file_core #(.WIDTH(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [3:0] d, input logic xv);
    bus.a       = op[1];
    bus.b       = op[0];
    bus.data_in = d;
    bus.x       = xv;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(2'b00, 4'd0, 1'b0);
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(2'b01, 4'd9, 1'b0);
    tick();
    total++;
    if (bus.data_out !== 4'd0) begin
      bad++; $display("FAIL reset_data got=%0d want=0", bus.data_out);
    end
    total++;
    if (bus.out !== 1'b0) begin
      bad++; $display("FAIL reset_out got=%b want=0", bus.out);
    end
    rst = 1'b1;
    drive(2'b00, 4'd9, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (bus.data_out !== 4'd0) begin
        bad++; $display("FAIL reset_hold[%0d] got=%0d want=0", i, bus.data_out);
      end
    end
  endtask

  task automatic test_opcodes();
    logic [1:0] ops  [5] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b00};
    logic [3:0] din  [5] = '{4'd5, 4'd3, 4'hF, 4'd2, 4'd6};
    logic [3:0] want [5] = '{4'd5, 4'd8, 4'd7, 4'd7, 4'd7};
    for (int i = 0; i < 5; i++) begin
      drive(ops[i], din[i], 1'b0);
      tick();
      total++;
      if (bus.data_out !== want[i]) begin
        bad++; $display("FAIL opcode[%0d] got=%0d want=%0d", i, bus.data_out, want[i]);
      end
    end
  endtask

  task automatic test_wrap();
    drive(2'b01, 4'd15, 1'b0);
    tick();
    total++;
    if (bus.data_out !== 4'd15) begin
      bad++; $display("FAIL wrap_load got=%0d want=15", bus.data_out);
    end
    drive(2'b10, 4'd1, 1'b0);
    tick();
    total++;
    if (bus.data_out !== 4'd0) begin
      bad++; $display("FAIL wrap_add got=%0d want=0", bus.data_out);
    end
  endtask

  task automatic test_overlap();
    logic xs   [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic want [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(2'b00, 4'd0, xs[i]);
      tick();
      total++;
      if (bus.out !== want[i]) begin
        bad++; $display("FAIL overlap[%0d] got=%b want=%b", i, bus.out, want[i]);
      end
    end
  endtask

  task automatic test_near_miss();
    logic xa [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic xb [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(2'b00, 4'd0, xa[i]);
      tick();
      total++;
      if (bus.out !== 1'b0) begin
        bad++; $display("FAIL near_a[%0d] got=%b want=0", i, bus.out);
      end
    end
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(2'b00, 4'd0, xb[i]);
      tick();
      total++;
      if (bus.out !== 1'b0) begin
        bad++; $display("FAIL near_b[%0d] got=%b want=0", i, bus.out);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic xs [3] = '{1'b1, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, 4'd0, xs[i]);
      tick();
    end
    rst = 1'b0;
    drive(2'b01, 4'd7, 1'b1);
    tick();
    total++;
    if (bus.out !== 1'b0 || bus.data_out !== 4'd0) begin
      bad++; $display("FAIL mid_reset got=%b/%0d want=0/0", bus.out, bus.data_out);
    end
    rst = 1'b1;
    drive(2'b00, 4'd0, 1'b1);
    tick();
    total++;
    if (bus.out !== 1'b0) begin
      bad++; $display("FAIL mid_restart got=%b want=0", bus.out);
    end
  endtask

  task automatic test_random();
    // Next-state tables indexed by prefix length matched: 0,1,10,101,1011.
    int         nxt0 [5] = '{0, 2, 0, 2, 2};
    int         nxt1 [5] = '{1, 1, 3, 4, 1};
    int         m_st;
    logic [3:0] m_data;
    logic [1:0] op;
    logic [3:0] d;
    logic       xv;
    do_reset();
    m_st   = 0;
    m_data = 4'd0;
    for (int i = 0; i < 16; i++) begin
      op  = 2'($urandom_range(0, 3));
      d   = 4'($urandom_range(0, 15));
      xv  = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 7) != 0);
      drive(op, d, xv);
      if (!rst) begin
        m_data = 4'd0;
        m_st   = 0;
      end else begin
        case (op)
          2'b01:   m_data = d;
          2'b10:   m_data = 4'((int'(m_data) + int'(d)) % 16);
          2'b11:   m_data = m_data ^ d;
          default: m_data = m_data;
        endcase
        m_st = xv ? nxt1[m_st] : nxt0[m_st];
      end
      tick();
      total++;
      if (bus.data_out !== m_data || bus.out !== (m_st == 4)) begin
        bad++;
        $display("FAIL random[%0d] got=%0d/%b want=%0d/%b",
                 i, bus.data_out, bus.out, m_data, (m_st == 4));
      end
    end
    rst = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive(2'b00, 4'd0, 1'b0);
    #2;
    test_reset();
    test_opcodes();
    test_wrap();
    test_overlap();
    test_near_miss();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
